// File: rtl/vector_cache_pkg.sv
// Shared vector-cache definitions: data-buffer index width and WDB allocator types.
package vector_cache_pkg;

  localparam int unsigned DB_ENTRY_IDX_WIDTH = 6;
  localparam int unsigned WDB_ENTRY_PER_LANE = 16;

  typedef enum logic {
    INIT,
    RUN
  } wdb_alloc_state_e;

endpackage

// File: rtl/wdb_free_list.sv
// Single-lane WDB free list: entry FIFO, in-use bitmap and release legality check.
module wdb_free_list
  import vector_cache_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = WDB_ENTRY_PER_LANE,
  parameter int unsigned CNT_W     = $clog2(ENTRY_NUM + 1),
  localparam int unsigned PTR_W    = $clog2(ENTRY_NUM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          init_we,
  input  logic                          init_last,
  input  logic [PTR_W-1:0]              init_idx,
  output logic                          alloc_vld,
  output logic [DB_ENTRY_IDX_WIDTH-1:0] alloc_idx,
  input  logic                          alloc_rdy,
  input  logic                          release_vld,
  input  logic [DB_ENTRY_IDX_WIDTH-1:0] release_idx,
  output logic [CNT_W-1:0]              count,
  output logic                          err_release
);

  logic [PTR_W-1:0]     fifo_q [ENTRY_NUM];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [ENTRY_NUM-1:0] inuse_q, inuse_d;
  logic                 err_q;
  logic [PTR_W-1:0]     head, rel_slot;
  logic                 pop, push, rel_legal;

  assign head      = fifo_q[rd_ptr_q];
  assign rel_slot  = release_idx[PTR_W-1:0];
  // Extra bit so ENTRY_NUM == 2**DB_ENTRY_IDX_WIDTH still compares correctly.
  assign rel_legal = ({1'b0, release_idx} < (DB_ENTRY_IDX_WIDTH + 1)'(ENTRY_NUM)) &&
                     inuse_q[rel_slot];
  assign alloc_vld = (count_q != '0);
  assign alloc_idx = alloc_vld ? DB_ENTRY_IDX_WIDTH'(head) : '0;
  assign pop       = alloc_vld && alloc_rdy;
  assign push      = run && release_vld && rel_legal;
  assign count       = count_q;
  assign err_release = err_q;

  always_comb begin
    inuse_d = inuse_q;
    if (push) inuse_d[rel_slot] = 1'b0;
    if (pop)  inuse_d[head]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      fifo_q[init_idx] <= init_idx;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= rel_slot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      inuse_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= run && release_vld && !rel_legal;
      if (init_last) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= CNT_W'(ENTRY_NUM);
      end else begin
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        inuse_q <= inuse_d;
      end
    end
  end

endmodule

// File: rtl/wdb_alloc_ctrl.sv
// Per-lane WDB entry allocator: shared init sequencer feeding one free list per lane.
module wdb_alloc_ctrl
  import vector_cache_pkg::*;
#(
  parameter int unsigned LANE_NUM  = 4,
  parameter int unsigned ENTRY_NUM = WDB_ENTRY_PER_LANE,
  parameter int unsigned CNT_W     = $clog2(ENTRY_NUM + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  output logic [LANE_NUM-1:0]                          alloc_vld,
  output logic [LANE_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]  alloc_idx,
  input  logic [LANE_NUM-1:0]                          alloc_rdy,
  input  logic [LANE_NUM-1:0]                          release_vld,
  input  logic [LANE_NUM-1:0][DB_ENTRY_IDX_WIDTH-1:0]  release_idx,
  output logic [LANE_NUM-1:0]                          release_rdy,
  output logic [LANE_NUM-1:0][CNT_W-1:0]               free_cnt,
  output logic                                         init_done,
  output logic [LANE_NUM-1:0]                          err_release
);

  localparam int unsigned PTR_W = $clog2(ENTRY_NUM);

  wdb_alloc_state_e state_q;
  logic [PTR_W-1:0] init_cnt_q;
  logic             init_done_q;
  logic             init_we, init_last, run;

  assign init_we     = (state_q == INIT);
  assign init_last   = init_we && (init_cnt_q == PTR_W'(ENTRY_NUM - 1));
  assign run         = (state_q == RUN);
  assign init_done   = init_done_q;
  assign release_rdy = {LANE_NUM{init_done_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_last) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  for (genvar l = 0; l < LANE_NUM; l++) begin : g_lane
    wdb_free_list #(
      .ENTRY_NUM (ENTRY_NUM),
      .CNT_W     (CNT_W)
    ) u_free_list (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .init_we     (init_we),
      .init_last   (init_last),
      .init_idx    (init_cnt_q),
      .alloc_vld   (alloc_vld[l]),
      .alloc_idx   (alloc_idx[l]),
      .alloc_rdy   (alloc_rdy[l]),
      .release_vld (release_vld[l]),
      .release_idx (release_idx[l]),
      .count       (free_cnt[l]),
      .err_release (err_release[l])
    );
  end

endmodule

// File: doc/wdb_alloc_ctrl.md
Name: wdb_alloc_ctrl

Overview:
Per-lane write-data-buffer (WDB) entry allocator that feeds the 4-lane write request crossbar's alloc_vld/alloc_idx/alloc_rdy handshake.
- Each lane owns a private pool of ENTRY_NUM data-buffer entries, tracked by a free-list FIFO and an in-use bitmap.
- Entries are handed out on alloc handshakes and returned by the WDB drain path via release.
- After reset, an init sequencer populates the free lists before any allocation is offered.

Parameters:
LANE_NUM, 4, number of independent lanes; matches the xbar output count.
ENTRY_NUM, 16, entries per lane; must be a power of two, ≥2, and ≤ 2**DB_ENTRY_IDX_WIDTH.
CNT_W, $clog2(ENTRY_NUM+1), width of the free-count outputs (derived).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
alloc_vld  out  LANE_NUM  lane has a free entry offered.
alloc_idx  out  DB_ENTRY_IDX_WIDTH x LANE_NUM  offered lane-local entry index; upper unused bits are 0.
alloc_rdy  in  LANE_NUM  consumer takes the offered entry.
release_vld  in  LANE_NUM  entry return request.
release_idx  in  DB_ENTRY_IDX_WIDTH x LANE_NUM  entry being returned.
release_rdy  out  LANE_NUM  release accepted; 1 whenever init_done.
free_cnt  out  CNT_W x LANE_NUM  current free entries per lane.
init_done  out  1  free lists populated.
err_release  out  LANE_NUM  1-cycle pulse: illegal release dropped.

Behaviour:
- Reset values:
  - alloc_vld=0, release_rdy=0, free_cnt=0, init_done=0, err_release=0, alloc_idx=0.
  - FSM=INIT, init counter=0, all FIFO pointers=0, in-use bitmap all 0.
- FSM states: INIT, RUN. There is no other state.
- INIT:
  - Each cycle, every lane writes the counter value into its FIFO slot[cnt].
  - After ENTRY_NUM cycles (cnt==ENTRY_NUM-1): wr_ptr wraps to 0, count=ENTRY_NUM, FSM→RUN.
  - init_done and free_cnt=ENTRY_NUM become visible on the first RUN cycle.
  - Reset-to-RUN latency is exactly ENTRY_NUM cycles.
  - Inputs are ignored in INIT.
- RUN, per lane, all lanes fully independent:
  - alloc_vld = (count!=0); alloc_idx = FIFO[rd_ptr], zero-extended.
  - Alloc fires on alloc_vld&&alloc_rdy: pop, rd_ptr++, set inuse[alloc_idx].
  - alloc_rdy without alloc_vld has no effect.
  - alloc_vld/alloc_idx stay stable until taken.
- Release in RUN:
  - release_rdy=1 always.
  - A release is legal iff release_idx < ENTRY_NUM and inuse[release_idx]==1.
  - Legal release: push to FIFO[wr_ptr], wr_ptr++, clear inuse bit.
  - Illegal release (double-free or out-of-range): no state change; err_release pulses the next cycle.
- Simultaneous alloc and legal release in one lane in the same cycle:
  - Both occur and count is unchanged.
  - The returned entry is never bypassed to alloc_idx in that cycle.
- Empty lane + release: alloc_vld rises the cycle after the release, with alloc_idx = the released index.
- Full lane (count==ENTRY_NUM): a legal release cannot occur because the bitmap is all 0, so FIFO overflow is structurally impossible.
- Pointer arithmetic:
  - rd_ptr/wr_ptr are $clog2(ENTRY_NUM) bits and wrap naturally.
  - count is CNT_W bits and is updated as count + push − pop.
  - free_cnt = count, registered.
- Reset asserted mid-operation: immediately returns to reset values.
  - All outstanding entries are implicitly reclaimed.
  - Upstream must not issue releases for entries allocated before the reset.

Decomposition:
- vector_cache_pkg:
  - reuse DB_ENTRY_IDX_WIDTH.
  - add WDB_ENTRY_PER_LANE (=ENTRY_NUM default).
  - add typedef wdb_alloc_state_e {INIT, RUN}.
- One sub-module, wdb_free_list: single-lane FIFO plus in-use bitmap plus legality check.
  - Instantiated LANE_NUM times.
  - The top holds the shared init FSM/counter and drives the init write port of every instance.

Test Plan:
- Reset release, check INIT: init_done=0, alloc_vld=0 for 16 cycles → cycle 16: init_done=1, free_cnt=16 on all lanes, lane0 alloc_idx=0.
- Lane 2 alloc_rdy held high 16 cycles → alloc_idx sequence 0..15, then alloc_vld[2]=0 and free_cnt[2]=0; other lanes remain at 16.
- Drain lane 0, release idx 7 → next cycle alloc_vld[0]=1, alloc_idx[0]=7, free_cnt[0]=1.
- Lane 1 at count 10, alloc and release of idx 3 (in use) in the same cycle → free_cnt[1] stays 10; idx 3 lands at the FIFO tail, not on alloc_idx.
- Release idx 5 on lane 3 while free, and release idx 16 (out of range) → err_release[3] pulses 1 cycle each; free_cnt[3] is unchanged.
- Assert rst after 5 allocs on lane 0 → outputs return to reset values immediately; re-init completes after 16 cycles with free_cnt[0]=16 and alloc sequence restarting at 0.
